// File: rtl/rv_asm_pkg.sv
// Shared op codes and RV32I encoding constants for the instruction assembler.
package rv_asm_pkg;

   typedef enum logic [3:0] {
      OP_LW   = 4'd0,
      OP_LBU  = 4'd1,
      OP_JALR = 4'd2,
      OP_JAL  = 4'd3,
      OP_ADD  = 4'd4,
      OP_SUB  = 4'd5,
      OP_BNE  = 4'd6,
      OP_LUI  = 4'd7,
      OP_ADDI = 4'd8,
      OP_SW   = 4'd9
   } rv_op_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_ZERO = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= 4'd9);
   endfunction

endpackage

// File: rtl/rv_asm_fifo.sv
// Synchronous DEPTH x W FIFO with flush; pointers carry a wrap bit for full/empty.
module rv_asm_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic         push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/rv_instr_assembler.sv
// RV32I encoder feeding a word FIFO with auto-incrementing output address.
// Optional RV_ASM_ILLEGAL_TRAP_EN: illegal ops are dropped and set sticky err.
module rv_instr_assembler
   import rv_asm_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       count,
   output logic              err
);
   logic [31:0]       enc_word;
   logic [31:0]       fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic              accept, push, pop;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       count_q, count_d;

   always_comb begin
      enc_word = NOP_INSTR;
      case (in_op)
         OP_LW:   enc_word = {in_imm[11:0], in_rs1, F3_LW, in_rd, OPC_LOAD};
         OP_LBU:  enc_word = {in_imm[11:0], in_rs1, F3_LBU, in_rd, OPC_LOAD};
         OP_JALR: enc_word = {in_imm[11:0], in_rs1, F3_ZERO, in_rd, OPC_JALR};
         OP_JAL:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, OPC_JAL};
         OP_ADD:  enc_word = {F7_ADD, in_rs2, in_rs1, F3_ZERO, in_rd, OPC_OP};
         OP_SUB:  enc_word = {F7_SUB, in_rs2, in_rs1, F3_ZERO, in_rd, OPC_OP};
         OP_BNE:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BNE,
                              in_imm[4:1], in_imm[11], OPC_BRANCH};
         OP_LUI:  enc_word = {in_imm[31:12], in_rd, OPC_LUI};
         OP_ADDI: enc_word = {in_imm[11:0], in_rs1, F3_ZERO, in_rd, OPC_OPIMM};
         OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_SW, in_imm[4:0], OPC_STORE};
         default: enc_word = NOP_INSTR;
      endcase
   end

   // in_ready depends only on registered pointers, never on out_ready
   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign accept    = in_valid && in_ready && !rst && !clr;
   assign pop       = out_valid && out_ready && !rst && !clr;

`ifdef RV_ASM_ILLEGAL_TRAP_EN
   logic err_q;

   assign push = accept && op_legal(in_op);
   assign err  = err_q;

   always_ff @(posedge clk) begin
      if (rst)                              err_q <= 1'b0;
      else if (accept && !op_legal(in_op))  err_q <= 1'b1;
   end
`else
   assign push = accept;
   assign err  = 1'b0;
`endif

   rv_asm_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push),
      .wdata (enc_word),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      if (pop) begin
         addr_d = addr_q + ADDR_W'(4);
         if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         addr_q  <= BASE_ADDR;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

   assign out_instr = fifo_empty ? 32'h0 : fifo_rdata;
   assign out_addr  = addr_q;
   assign count     = count_q;

endmodule

// File: doc/rv_instr_assembler.md
# rv_instr_assembler

Sequential RV32I instruction assembler: accepts symbolic instruction requests (operation, registers, immediate) over a valid/ready handshake and encodes them into 32-bit instruction words. Words are buffered in a small FIFO and emitted with an auto-incrementing byte address toward the instruction-memory write port. It is the encoding-side counterpart of `UnidadControl`: every word it produces decodes there to the intended control signals. It is used for program loading and self-checking test programs.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `ADDR_W`, 32: output address width.
- `BASE_ADDR`, 0: first emitted address; must be a multiple of 4.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous flush: empties FIFO, reloads address; reset-equivalent except `err`.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when both high.
- `in_op`  in  4  0 LW, 1 LBU, 2 JALR, 3 JAL, 4 ADD, 5 SUB, 6 BNE, 7 LUI, 8 ADDI, 9 SW; 10–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices; fields unused by the format are ignored.
- `in_imm`  in  32  I/S: [11:0]; B: [12:1]; J: [20:1]; U: [31:12]. Other bits ignored.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer takes word when both high.
- `out_instr`  out  32  encoded word (FIFO head).
- `out_addr`  out  ADDR_W  byte address of `out_instr`.
- `count`  out  16  words emitted since reset/`clr`; saturates at 0xFFFF.
- `err`  out  1  sticky illegal-op flag (only with macro, else tied 0).

## Operation

- Encoding uses standard RV32I formats:
  - LW/LBU: opcode 0000011, funct3 010/100.
  - JALR: 1100111/000.
  - JAL: 1101111.
  - ADD/SUB: 0110011, funct3 000, funct7 0000000/0100000.
  - BNE: 1100011/001.
  - LUI: 0110111.
  - ADDI: 0010011/000.
  - SW: 0100011/010.
- Encoding is combinational on the accepted inputs; the word is written into the FIFO at the accept edge.
- Illegal op without macro: encoded as NOP 0x00000013 and enqueued normally.
- `out_addr` register: starts `BASE_ADDR`; +4 on each output handshake; wraps modulo 2^ADDR_W.
- Reset values: FIFO empty, `out_valid`=0, `in_ready`=1, `out_addr`=`BASE_ADDR`, `count`=0, `err`=0, `out_instr`=0.

## Timing

- Latency: accept at edge N, `out_valid`=1 after edge N (visible cycle N+1) when FIFO was empty.
- Throughput: one word per cycle sustained.
- `in_ready` = !full, registered-state-derived. No combinational path from `out_ready` to `in_ready`, so no accept while full even if popping that cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- `out_instr`/`out_addr` remain stable while `out_valid`=1 and `out_ready`=0.
- `rst` or `clr` mid-stream: a same-cycle handshake is discarded, FIFO is emptied on the next edge, and no word is emitted for it.
- `clr` has priority over push/pop. `rst` additionally clears `err`.

## Configuration

- `RV_ASM_ILLEGAL_TRAP_EN` defined: an illegal `in_op` is accepted (handshake completes) but not enqueued, and sets `err` on that edge; `err` is cleared only by `rst`.
- Undefined: illegal ops become NOP, `err` is constant 0.

## Structure

- Shared package/header `rv_asm_pkg`: `in_op` codes, opcode/funct3/funct7 constants, NOP constant.
- One sub-module `rv_asm_fifo` (synchronous FIFO, DEPTH×32, full/empty, flush). The encoder and address/count logic sit in the top.

## Test plan

- ADD x3,x1,x2 with out_ready=1 → out_instr 0x002081B3 at out_addr 0x0 one cycle after accept. SUB, same regs → 0x402081B3 at 0x4.
- LW x5,8(x2) → 0x00812283. LUI x1,0x12345 (in_imm=0x12345000) → 0x123450B7. JAL x1,+8 → 0x008000EF.
- out_ready=0, push 5 requests with DEPTH=4 → in_ready low after 4th accept; release out_ready → words emerge in order at 0x0,0x4,0x8,0xC, and 5th is accepted after first pop.
- BASE_ADDR=0xFFFFFFFC, two words → addresses 0xFFFFFFFC then 0x00000000.
- in_op=12: without macro → 0x00000013 emitted; with macro → nothing emitted, err=1 until rst, and `clr` leaves err=1.
- clr asserted with 3 words queued → next cycle out_valid=0, out_addr=BASE_ADDR, count=0.
